// File: rtl/fifo_rd_arbiter.sv
// fifo_rd_arbiter: round-robin read arbiter that shares one valid/ready sink
// among NUM_REQ show-ahead FIFO read ports, popping at most BURST_MAX words
// per grant.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | no grant; pick the next eligible FIFO after last_ptr
//   BURST | grant held; forward words from the granted FIFO to the sink

module fifo_rd_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_en,
    input  logic [NUM_REQ-1:0]            i_empty,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_rdata,
    output logic [NUM_REQ-1:0]            o_rinc,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    input  logic                          i_ready,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic                          o_busy
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [PTR_W-1:0]  LAST_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    gidx_q, gidx_d;
    logic [PTR_W-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [PTR_W-1:0]    pick;
    logic [PTR_W-1:0]    idx_p;
    int                  idx;
    logic                valid;
    logic                xfer;

    assign eligible = i_en & ~i_empty;

    // Round-robin search: first eligible index strictly after last_q, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        idx_p = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx   = (int'(last_q) + i) % NUM_REQ;
            idx_p = PTR_W'(idx);
            if (!found && eligible[idx_p]) begin
                found = 1'b1;
                pick  = idx_p;
            end
        end
    end

    // Datapath toward the sink; the word is gated to zero whenever not valid.
    always_comb begin
        valid  = (state_q == BURST) && i_en[gidx_q] && !i_empty[gidx_q];
        xfer   = valid && i_ready;
        o_data = '0;
        o_rinc = '0;
        if (valid) begin
            o_data = i_rdata[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
        end
        if (xfer) begin
            o_rinc[gidx_q] = 1'b1;
        end
    end

    // Next-state: grant in IDLE, count beats and decide when to release in BURST.
    always_comb begin
        state_d = state_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        grant_d = grant_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d       = BURST;
                    gidx_d        = pick;
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    beat_d        = '0;
                end
            end
            BURST: begin
                // An empty or disabled FIFO makes valid low, which also ends the grant.
                if (!valid || (xfer && (beat_q == BEAT_LAST))) begin
                    state_d = IDLE;
                    last_d  = gidx_q;
                    grant_d = '0;
                    beat_d  = '0;
                end else if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                beat_d  = '0;
            end
        endcase
        busy_d = (state_d == BURST);
    end

    // State and registered outputs; reset restarts arbitration at index 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            last_q  <= LAST_RST;
            grant_q <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            beat_q  <= beat_d;
            busy_q  <= busy_d;
        end
    end

    assign o_valid = valid;
    assign o_grant = grant_q;
    assign o_busy  = busy_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Testbench for fifo_rd_arbiter: FIFOs modelled as queues, a transaction-level
// reference of the arbitration rules, directed scenarios then random traffic.

module tb_fifo_rd_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    en;
    logic [N-1:0]    empty;
    logic [N*DW-1:0] rdata;
    logic [N-1:0]    rinc;
    logic            valid;
    logic [DW-1:0]   data;
    logic            ready;
    logic [N-1:0]    grant;
    logic            busy;

    fifo_rd_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_MAX(BM)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_en    (en),
        .i_empty (empty),
        .i_rdata (rdata),
        .o_rinc  (rinc),
        .o_valid (valid),
        .o_data  (data),
        .i_ready (ready),
        .o_grant (grant),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fq [N][$];
    int            tests = 0;
    int            fails = 0;

    // reference: who holds the sink, how many words it has taken, who went last
    bit            m_busy;
    int            m_g;
    int            m_beats;
    int            m_last;

    int            acc_src [$];
    logic [DW-1:0] acc_dat [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        for (int k = 0; k < N; k++) begin
            empty[k] = (fq[k].size() == 0);
            rdata[k*DW +: DW] = (fq[k].size() != 0) ? fq[k][0] : DW'($urandom);
        end
    endtask

    task automatic check_outputs();
        logic          ev;
        logic [DW-1:0] ed;
        logic [N-1:0]  eg;
        logic [N-1:0]  er;
        ev = m_busy && en[m_g] && (fq[m_g].size() != 0);
        ed = ev ? fq[m_g][0] : '0;
        eg = m_busy ? (N'(1) << m_g) : '0;
        er = (ev && ready) ? (N'(1) << m_g) : '0;
        check("valid", 32'(valid), 32'(ev));
        check("data",  32'(data),  32'(ed));
        check("grant", 32'(grant), 32'(eg));
        check("rinc",  32'(rinc),  32'(er));
        check("busy",  32'(busy),  32'(m_busy));
    endtask

    task automatic model_update();
        bit ok;
        int k;
        if (m_busy) begin
            ok = en[m_g] && (fq[m_g].size() != 0);
            if (ok && ready) begin
                acc_src.push_back(m_g);
                acc_dat.push_back(fq[m_g].pop_front());
                m_beats++;
            end
            if (!ok || m_beats == BM) begin
                m_busy = 0;
                m_last = m_g;
            end
        end else begin
            for (int i = 1; i <= N; i++) begin
                k = (m_last + i) % N;
                if (en[k] && fq[k].size() != 0) begin
                    m_busy  = 1;
                    m_g     = k;
                    m_beats = 0;
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        drive_fifo();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_acc();
        acc_src.delete();
        acc_dat.delete();
    endtask

    initial begin
        int exp_src [12] = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2, 2};
        int exp_seq [12] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 4, 5};
        int guard;
        int total;

        rst = 1'b1; en = '0; ready = 1'b0; empty = '1; rdata = '0;
        m_busy = 0; m_g = 0; m_beats = 0; m_last = N - 1;

        // reset state
        #2;
        drive_fifo();
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // no requesters for 20 cycles
        en = '1; ready = 1'b1;
        repeat (20) cycle();

        // round-robin burst cap: FIFO0 and FIFO2 hold 6 words each
        clear_acc();
        for (int i = 0; i < 6; i++) begin
            fq[0].push_back(DW'(8'h00 + i));
            fq[2].push_back(DW'(8'h20 + i));
        end
        repeat (26) cycle();
        check("rr_count", 32'(acc_src.size()), 32'd12);
        for (int i = 0; i < 12 && i < acc_src.size(); i++) begin
            check("rr_src", 32'(acc_src[i]), 32'(exp_src[i]));
            check("rr_dat", 32'(acc_dat[i]), 32'((exp_src[i] == 0 ? 8'h00 : 8'h20) + exp_seq[i]));
        end

        // single requester on FIFO1
        clear_acc();
        fq[1].push_back(8'hA1);
        fq[1].push_back(8'hA2);
        repeat (6) cycle();
        check("single_count", 32'(acc_src.size()), 32'd2);
        if (acc_dat.size() == 2) begin
            check("single_w0", 32'(acc_dat[0]), 32'h A1);
            check("single_w1", 32'(acc_dat[1]), 32'h A2);
            check("single_src", 32'(acc_src[1]), 32'd1);
        end
        check("single_idle", 32'(busy), 32'd0);

        // backpressure on FIFO3
        clear_acc();
        fq[3].push_back(8'h5C);
        ready = 1'b0;
        repeat (4) cycle();
        check("bp_held_valid", 32'(valid), 32'd1);
        check("bp_held_data", 32'(data), 32'h5C);
        check("bp_no_pop", 32'(acc_src.size()), 32'd0);
        ready = 1'b1;
        repeat (4) cycle();
        check("bp_pop_count", 32'(acc_src.size()), 32'd1);
        if (acc_dat.size() == 1) check("bp_pop_data", 32'(acc_dat[0]), 32'h5C);

        // enable drop mid-burst on FIFO0
        clear_acc();
        for (int i = 0; i < 5; i++) fq[0].push_back(DW'(8'h40 + i));
        fq[1].push_back(8'h51);
        fq[1].push_back(8'h52);
        guard = 0;
        while (acc_src.size() < 2 && guard < 20) begin
            cycle();
            guard++;
        end
        check("drop_wait_ok", 32'(guard < 20), 32'd1);
        en[0] = 1'b0;
        drive_fifo();
        @(negedge clk);
        check("drop_valid", 32'(valid), 32'd0);
        check("drop_rinc", 32'(rinc), 32'd0);
        @(posedge clk);
        model_update();
        #1;
        repeat (8) cycle();
        check("drop_fifo0_left", 32'(fq[0].size()), 32'd3);
        check("drop_total", 32'(acc_src.size()), 32'd4);
        if (acc_src.size() == 4) check("drop_next_src", 32'(acc_src[2]), 32'd1);
        en[0] = 1'b1;
        repeat (6) cycle();

        // asynchronous reset during a burst
        for (int k = 0; k < N; k++) begin
            while (fq[k].size() < 3) fq[k].push_back(DW'($urandom));
        end
        guard = 0;
        while (!(m_busy && m_beats >= 1) && guard < 20) begin
            cycle();
            guard++;
        end
        check("rst_wait_ok", 32'(guard < 20), 32'd1);
        total = fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size();
        drive_fifo();
        #2;
        rst = 1'b1;
        #1;
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        m_busy = 0; m_beats = 0; m_last = N - 1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_no_pop", 32'(fq[0].size() + fq[1].size() + fq[2].size() + fq[3].size()), 32'(total));
        cycle();
        check("rst_first_grant", 32'(grant), 32'b0001);

        // random traffic against the reference
        repeat (400) begin
            en    = ($urandom_range(0, 5) == 0) ? N'($urandom) : '1;
            ready = ($urandom_range(0, 3) != 0);
            cycle();
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 3) == 0 && fq[k].size() < 8) fq[k].push_back(DW'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
